// File: rtl/expr_misr_pkg.sv
// Shared types and constants for the expression-result MISR checker.
// Optional input skid register: define EXPR_MISR_PIPE_EN.
package expr_misr_pkg;

  // Width of the concatenated expression-block y bus.
  localparam int unsigned EXPR_W  = 90;
  localparam int unsigned MISR_CW = 16;

  localparam logic [EXPR_W-1:0] MISR_POLY = 90'h29;
  localparam logic [EXPR_W-1:0] MISR_SEED = 90'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_e;

endpackage

// File: rtl/misr_step.sv
// One MISR compression step: shift left, fold the MSB back through POLY, XOR data.
module misr_step
  import expr_misr_pkg::*;
#(
  parameter int unsigned  W    = EXPR_W,
  parameter logic [W-1:0] POLY = W'(MISR_POLY)
) (
  input  logic [W-1:0] sig,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig_next
);

  // Galois-style feedback, all at W bits unsigned.
  always_comb begin
    sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ data;
  end

endmodule

// File: rtl/expr_result_misr.sv
// Compresses a programmed number of y-bus vectors into a MISR signature and
// reports pass/fail against a golden value.
// Optional input skid register between handshake and MISR: EXPR_MISR_PIPE_EN.
module expr_result_misr
  import expr_misr_pkg::*;
#(
  parameter int unsigned  W    = EXPR_W,
  parameter int unsigned  CW   = MISR_CW,
  parameter logic [W-1:0] POLY = W'(MISR_POLY),
  parameter logic [W-1:0] SEED = W'(MISR_SEED)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] nvec,
  input  logic [W-1:0]  golden,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] count
);

  misr_state_e   state_q, state_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [W-1:0]  gold_q, gold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] nvec_q, nvec_d;
  logic          pass_q, pass_d;
  logic [W-1:0]  step_data, step_sig;
  logic          xfer, absorb;

`ifdef EXPR_MISR_PIPE_EN
  logic          skid_vld_q, skid_vld_d;
  logic [W-1:0]  skid_q, skid_d;
  logic [CW-1:0] acc_q, acc_d;

  // The skid drains into the MISR every RUN cycle, so only the accepted count gates ready.
  assign in_ready  = (state_q == ST_RUN) && (acc_q < nvec_q);
  assign step_data = skid_q;
`else
  assign in_ready  = (state_q == ST_RUN);
  assign step_data = in_y;
`endif

  assign xfer      = in_valid && in_ready;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

  misr_step #(.W(W), .POLY(POLY)) u_step (
    .sig      (sig_q),
    .data     (step_data),
    .sig_next (step_sig)
  );

  // Next-state: run control, MISR absorb and vector counting.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    gold_d  = gold_q;
    cnt_d   = cnt_q;
    nvec_d  = nvec_q;
    absorb  = 1'b0;
`ifdef EXPR_MISR_PIPE_EN
    skid_vld_d = 1'b0;
    skid_d     = skid_q;
    acc_d      = acc_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nvec_d  = nvec;
          gold_d  = golden;
          sig_d   = SEED;
          cnt_d   = '0;
          state_d = (nvec == '0) ? ST_DONE : ST_RUN;
`ifdef EXPR_MISR_PIPE_EN
          skid_d  = '0;
          acc_d   = '0;
`endif
        end
      end
      ST_RUN: begin
`ifdef EXPR_MISR_PIPE_EN
        if (xfer) begin
          skid_vld_d = 1'b1;
          skid_d     = in_y;
          acc_d      = acc_q + CW'(1);
        end
        absorb = skid_vld_q;
`else
        absorb = xfer;
`endif
        if (absorb) begin
          sig_d = step_sig;
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q + CW'(1)) == nvec_q) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pass_d = (state_d == ST_DONE) && (sig_d == gold_d);
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      gold_q  <= '0;
      cnt_q   <= '0;
      nvec_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      gold_q  <= gold_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
      pass_q  <= pass_d;
    end
  end

`ifdef EXPR_MISR_PIPE_EN
  // Skid register and accepted-vector count.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      acc_q      <= '0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      acc_q      <= acc_d;
    end
  end
`endif

endmodule
